dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single shared memory port. It serialises instruction fetches from IF and data loads/stores from MEM onto one request/ready memory interface, and returns read data with a one-cycle completion pulse. It drives per-requester stall signals so the pipeline holds while an access is outstanding. It sits between the IF/MEM stages and the unified memory.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (fetch/data) arbiter sequencing requests onto one shared memory port, data-first priority.
// Optional fetch anti-starvation counter enabled by defining DMEM_ARB_FAIR_EN.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  d_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;

  logic i_elig, d_elig, fetch_first, grant_i, grant_d;

  // A port whose completion pulse is visible this cycle must not be re-granted.
  assign i_elig  = i_req & ~i_done_q;
  assign d_elig  = d_req & ~d_done_q;
  assign grant_d = (state_q == IDLE) & d_elig & ~fetch_first;
  assign grant_i = (state_q == IDLE) & i_elig & ~grant_d;

`ifdef DMEM_ARB_FAIR_EN
  localparam logic [2:0] FAIR_LIM3 = FAIR_LIMIT[2:0];
  logic [2:0] fair_cnt_q, fair_cnt_d;

  assign fetch_first = (fair_cnt_q == FAIR_LIM3) & i_elig;

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (grant_i) begin
      fair_cnt_d = 3'd0;
    end else if (grant_d) begin
      if (!i_req) begin
        fair_cnt_d = 3'd0;
      end else if (fair_cnt_q != 3'd7) begin
        fair_cnt_d = fair_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fair_cnt_q <= 3'd0;
    else     fair_cnt_q <= fair_cnt_d;
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
          addr_d  = d_addr;
          we_d    = d_we;
          be_d    = d_be;
          wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d = BUSY_I;
          addr_d  = i_addr;
          we_d    = 1'b0;
          be_d    = 4'hF;
          wdata_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          i_rdata_d = mem_rdata;
          i_done_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          d_rdata_d = mem_rdata;
          d_done_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule
